// File: rtl/blk_mem_sdp_param_pkg.sv
// Shared constants and helpers for the block-RAM family: read-during-write
// mode encodings and a lane-wise merge of a new word into an old one.
package blk_mem_sdp_param_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MergeMaxWidth = 256;

  function automatic logic [MergeMaxWidth-1:0] lane_merge(
    input logic [MergeMaxWidth-1:0] old_word,
    input logic [MergeMaxWidth-1:0] new_word,
    input logic [MergeMaxWidth-1:0] lane_mask,
    input int                       lane_width
  );
    logic [MergeMaxWidth-1:0] merged;
    int                       lane;
    merged = old_word;
    for (int b = 0; b < MergeMaxWidth; b++) begin
      lane = b / lane_width;
      if (lane_mask[lane[7:0]]) merged[b[7:0]] = new_word[b[7:0]];
    end
    return merged;
  endfunction

endpackage

// File: rtl/blk_mem_sdp_param_if.sv
// Port bundle of the simple dual-port RAM: write port A, read port B and read result.
interface blk_mem_sdp_param_if #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 9,
  parameter int NumLanes  = 1
);
  logic                 ena;
  logic [NumLanes-1:0]  wea;
  logic [AddrWidth-1:0] addra;
  logic [DataWidth-1:0] dina;
  logic                 enb;
  logic                 regceb;
  logic [AddrWidth-1:0] addrb;
  logic [DataWidth-1:0] doutb;
  logic                 validb;

  modport master (
    output ena, wea, addra, dina, enb, regceb, addrb,
    input  doutb, validb
  );

  modport slave (
    input  ena, wea, addra, dina, enb, regceb, addrb,
    output doutb, validb
  );
endinterface

// File: rtl/blk_mem_sdp_param_out_stage.sv
// Read-valid pipeline and the optional output register on the read port.
module blk_mem_sdp_param_out_stage #(
  parameter int DataWidth = 9,
  parameter int OutReg    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic                 regce,
  input  logic [DataWidth-1:0] rd_data,
  output logic [DataWidth-1:0] dout,
  output logic                 valid
);

  logic vld1_q, vld1_d;

  always_comb begin
    vld1_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) vld1_q <= 1'b0;
    else       vld1_q <= vld1_d;
  end

  if (OutReg == 1) begin : g_oreg
    logic [DataWidth-1:0] oreg_q, oreg_d;
    logic                 vld2_q, vld2_d;

    // Data and valid advance together so a frozen stage never mislabels data.
    always_comb begin
      oreg_d = oreg_q;
      vld2_d = vld2_q;
      if (regce) begin
        oreg_d = rd_data;
        vld2_d = vld1_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        oreg_q <= '0;
        vld2_q <= 1'b0;
      end else begin
        oreg_q <= oreg_d;
        vld2_q <= vld2_d;
      end
    end

    assign dout  = oreg_q;
    assign valid = vld2_q;
  end else begin : g_no_oreg
    logic unused_regce;
    assign unused_regce = regce;
    assign dout         = rd_data;
    assign valid        = vld1_q;
  end

endmodule

// File: rtl/blk_mem_sdp_param.sv
// Parametrised single-clock simple dual-port RAM: port A writes with lane enables,
// port B reads with selectable read-during-write behaviour and optional output register.
module blk_mem_sdp_param
  import blk_mem_sdp_param_pkg::*;
#(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 9,
  parameter int NumLanes  = 1,
  parameter int OutReg    = 0,
  parameter int RdwMode   = 0
) (
  input logic                clk,
  input logic                reset,
  blk_mem_sdp_param_if.slave mem_if
);

  localparam int LaneWidth = DataWidth / NumLanes;
  localparam int Depth     = 1 << AddrWidth;

  if (DataWidth % NumLanes != 0) begin : g_bad_lanes
    $error("DataWidth must be a multiple of NumLanes");
  end
  if (OutReg != 0 && OutReg != 1) begin : g_bad_outreg
    $error("OutReg must be 0 or 1");
  end
  if (RdwMode != RDW_WRITE_FIRST && RdwMode != RDW_READ_FIRST) begin : g_bad_rdw
    $error("RdwMode must be RDW_WRITE_FIRST or RDW_READ_FIRST");
  end
  if (DataWidth > MergeMaxWidth) begin : g_too_wide
    $error("DataWidth exceeds lane_merge capacity");
  end

  logic [DataWidth-1:0] mem [Depth];
  logic [NumLanes-1:0]  wr_lanes;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] rd_fwd;
  logic [DataWidth-1:0] latch_q, latch_d;

  assign wr_lanes = mem_if.ena ? mem_if.wea : '0;

  // Kept as a bare lane loop with no reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (wr_lanes[i])
          mem[mem_if.addra][i*LaneWidth +: LaneWidth] <= mem_if.dina[i*LaneWidth +: LaneWidth];
      end
    end
  end

  always_comb begin
    rd_word = mem[mem_if.addrb];
    rd_fwd  = rd_word;
    if (RdwMode == RDW_WRITE_FIRST && mem_if.addra == mem_if.addrb)
      rd_fwd = DataWidth'(lane_merge(MergeMaxWidth'(rd_word), MergeMaxWidth'(mem_if.dina),
                                     MergeMaxWidth'(wr_lanes), LaneWidth));
    latch_d = latch_q;
    if (mem_if.enb) latch_d = rd_fwd;
  end

  always_ff @(posedge clk) begin
    if (reset) latch_q <= '0;
    else       latch_q <= latch_d;
  end

  blk_mem_sdp_param_out_stage #(
    .DataWidth (DataWidth),
    .OutReg    (OutReg)
  ) u_out_stage (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (mem_if.enb),
    .regce   (mem_if.regceb),
    .rd_data (latch_q),
    .dout    (mem_if.doutb),
    .valid   (mem_if.validb)
  );

endmodule

// File: tb/tb_blk_mem_sdp_param.sv
// Bench for blk_mem_sdp_param: directed checks on default and output-register builds,
// table-driven lane/collision vectors and a scoreboarded random run on two 4-lane builds.
module tb_blk_mem_sdp_param;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  blk_mem_sdp_param_if #(.AddrWidth(12), .DataWidth(9),  .NumLanes(1)) d_if ();
  blk_mem_sdp_param_if #(.AddrWidth(12), .DataWidth(9),  .NumLanes(1)) o_if ();
  blk_mem_sdp_param_if #(.AddrWidth(8),  .DataWidth(32), .NumLanes(4)) w_if ();
  blk_mem_sdp_param_if #(.AddrWidth(8),  .DataWidth(32), .NumLanes(4)) r_if ();

  blk_mem_sdp_param #(.AddrWidth(12), .DataWidth(9), .NumLanes(1), .OutReg(0), .RdwMode(0))
    u_dflt (.clk(clk), .reset(reset), .mem_if(d_if));
  blk_mem_sdp_param #(.AddrWidth(12), .DataWidth(9), .NumLanes(1), .OutReg(1), .RdwMode(0))
    u_oreg (.clk(clk), .reset(reset), .mem_if(o_if));
  blk_mem_sdp_param #(.AddrWidth(8), .DataWidth(32), .NumLanes(4), .OutReg(0), .RdwMode(0))
    u_wf (.clk(clk), .reset(reset), .mem_if(w_if));
  blk_mem_sdp_param #(.AddrWidth(8), .DataWidth(32), .NumLanes(4), .OutReg(1), .RdwMode(1))
    u_rf (.clk(clk), .reset(reset), .mem_if(r_if));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] wf_d;
    logic        wf_v;
    logic [31:0] rf_d;
    logic        rf_v;
  } exp_t;

  exp_t sb_q[$];

  // Reference state for the two 4-lane builds (they always see identical stimulus).
  logic [31:0] ref_mem [256];
  logic [31:0] m_wf_latch, m_rf_latch, m_rf_oreg;
  logic        m_wf_vld, m_rf_vld1, m_rf_vld2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_wide(input logic ena, input logic [3:0] wea, input logic [7:0] addra,
                          input logic [31:0] dina, input logic enb, input logic regceb,
                          input logic [7:0] addrb);
    w_if.ena = ena;  w_if.wea = wea;  w_if.addra = addra;  w_if.dina = dina;
    w_if.enb = enb;  w_if.regceb = regceb;  w_if.addrb = addrb;
    r_if.ena = ena;  r_if.wea = wea;  r_if.addra = addra;  r_if.dina = dina;
    r_if.enb = enb;  r_if.regceb = regceb;  r_if.addrb = addrb;
  endtask

  // Predict the effect of the coming edge on the 4-lane builds and queue it.
  task automatic model_step();
    logic [31:0] old_w, mix_w;
    exp_t        e;
    old_w = ref_mem[w_if.addrb];
    mix_w = old_w;
    for (int l = 0; l < 4; l++)
      if (w_if.ena && w_if.wea[l]) mix_w[l*8 +: 8] = w_if.dina[l*8 +: 8];
    if (reset) begin
      m_wf_latch = '0; m_wf_vld = 1'b0;
      m_rf_latch = '0; m_rf_vld1 = 1'b0; m_rf_oreg = '0; m_rf_vld2 = 1'b0;
    end else begin
      if (r_if.regceb) begin
        m_rf_oreg = m_rf_latch;
        m_rf_vld2 = m_rf_vld1;
      end
      if (w_if.enb) begin
        m_wf_latch = (w_if.addra == w_if.addrb) ? mix_w : old_w;
        m_rf_latch = old_w;
      end
      m_wf_vld  = w_if.enb;
      m_rf_vld1 = w_if.enb;
      for (int l = 0; l < 4; l++)
        if (w_if.ena && w_if.wea[l]) ref_mem[w_if.addra][l*8 +: 8] = w_if.dina[l*8 +: 8];
    end
    e.wf_d = m_wf_latch; e.wf_v = m_wf_vld;
    e.rf_d = m_rf_oreg;  e.rf_v = m_rf_vld2;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got no queued result, expected one entry");
    end else begin
      e = sb_q.pop_front();
      check("sb_wf_doutb",  w_if.doutb,  e.wf_d);
      check("sb_wf_validb", 32'(w_if.validb), 32'(e.wf_v));
      check("sb_rf_doutb",  r_if.doutb,  e.rf_d);
      check("sb_rf_validb", 32'(r_if.validb), 32'(e.rf_v));
    end
  endtask

  task automatic set_d(input logic ena, input logic [11:0] addra, input logic [8:0] dina,
                       input logic enb, input logic [11:0] addrb);
    d_if.ena = ena; d_if.wea = 1'b1; d_if.addra = addra; d_if.dina = dina;
    d_if.enb = enb; d_if.regceb = 1'b0; d_if.addrb = addrb;
  endtask

  task automatic set_o(input logic ena, input logic [11:0] addra, input logic [8:0] dina,
                       input logic enb, input logic regceb, input logic [11:0] addrb);
    o_if.ena = ena; o_if.wea = 1'b1; o_if.addra = addra; o_if.dina = dina;
    o_if.enb = enb; o_if.regceb = regceb; o_if.addrb = addrb;
  endtask

  task automatic chk_d(input string name, input logic [8:0] d, input logic v);
    check({name, "_doutb"},  32'(d_if.doutb),  32'(d));
    check({name, "_validb"}, 32'(d_if.validb), 32'(v));
  endtask

  task automatic chk_o(input string name, input logic [8:0] d, input logic v);
    check({name, "_doutb"},  32'(o_if.doutb),  32'(d));
    check({name, "_validb"}, 32'(o_if.validb), 32'(v));
  endtask

  typedef struct {
    logic        ena;
    logic [3:0]  wea;
    logic [7:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [7:0]  addrb;
    logic        chk_wf;
    logic [31:0] wf_d;
    logic        wf_v;
    logic        chk_rf;
    logic [31:0] rf_d;
    logic        rf_v;
  } row_t;

  row_t rows [7];

  initial begin
    // Lane writes, then same-edge collision in both modes (rf build has 2-cycle latency).
    rows[0] = '{1'b1, 4'hF,    8'd5, 32'hDEADBEEF, 1'b0, 8'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    rows[1] = '{1'b1, 4'b0101, 8'd5, 32'h11223344, 1'b0, 8'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    rows[2] = '{1'b0, 4'h0,    8'd0, 32'h0,        1'b1, 8'd5, 1'b1, 32'hDE22BE44, 1'b1, 1'b0, 32'h0,        1'b0};
    rows[3] = '{1'b1, 4'hF,    8'd7, 32'hAAAAAAAA, 1'b0, 8'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDE22BE44, 1'b1};
    rows[4] = '{1'b1, 4'b0011, 8'd7, 32'h55555555, 1'b1, 8'd7, 1'b1, 32'hAAAA5555, 1'b1, 1'b0, 32'h0,        1'b0};
    rows[5] = '{1'b0, 4'h0,    8'd0, 32'h0,        1'b1, 8'd7, 1'b1, 32'hAAAA5555, 1'b1, 1'b1, 32'hAAAAAAAA, 1'b1};
    rows[6] = '{1'b0, 4'h0,    8'd0, 32'h0,        1'b0, 8'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hAAAA5555, 1'b1};

    for (int a = 0; a < 256; a++) ref_mem[a] = '0;
    m_wf_latch = '0; m_wf_vld = 1'b0;
    m_rf_latch = '0; m_rf_vld1 = 1'b0; m_rf_oreg = '0; m_rf_vld2 = 1'b0;

    reset = 1'b1;
    set_wide(1'b0, 4'h0, 8'd0, 32'h0, 1'b0, 1'b1, 8'd0);
    set_d(1'b0, 12'h0, 9'h0, 1'b0, 12'h0);
    set_o(1'b0, 12'h0, 9'h0, 1'b0, 1'b1, 12'h0);
    #2;
    tick();
    tick();
    chk_d("reset_dflt", 9'h0, 1'b0);
    chk_o("reset_oreg", 9'h0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      set_wide(rows[i].ena, rows[i].wea, rows[i].addra, rows[i].dina, rows[i].enb, 1'b1,
               rows[i].addrb);
      tick();
      if (rows[i].chk_wf) begin
        check($sformatf("vec%0d_wf_doutb", i),  w_if.doutb,  rows[i].wf_d);
        check($sformatf("vec%0d_wf_validb", i), 32'(w_if.validb), 32'(rows[i].wf_v));
      end
      if (rows[i].chk_rf) begin
        check($sformatf("vec%0d_rf_doutb", i),  r_if.doutb,  rows[i].rf_d);
        check($sformatf("vec%0d_rf_validb", i), 32'(r_if.validb), 32'(rows[i].rf_v));
      end
    end
    set_wide(1'b0, 4'h0, 8'd0, 32'h0, 1'b0, 1'b1, 8'd0);

    // Default build: one-cycle read latency.
    set_d(1'b1, 12'h123, 9'h1A5, 1'b0, 12'h0);
    tick();
    chk_d("t1_after_write", 9'h0, 1'b0);
    set_d(1'b0, 12'h0, 9'h0, 1'b1, 12'h123);
    tick();
    chk_d("t1_read", 9'h1A5, 1'b1);
    set_d(1'b0, 12'h0, 9'h0, 1'b0, 12'h0);
    tick();
    chk_d("t1_idle_hold", 9'h1A5, 1'b0);

    // Output-register build: two-cycle latency and regceb freeze.
    set_o(1'b1, 12'h123, 9'h0AB, 1'b0, 1'b1, 12'h0);
    tick();
    set_o(1'b1, 12'h000, 9'h155, 1'b0, 1'b1, 12'h0);
    tick();
    set_o(1'b0, 12'h0, 9'h0, 1'b1, 1'b1, 12'h123);
    tick();
    chk_o("t4_lat1", 9'h0, 1'b0);
    set_o(1'b0, 12'h0, 9'h0, 1'b0, 1'b1, 12'h0);
    tick();
    chk_o("t4_lat2", 9'h0AB, 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_o(1'b0, 12'h0, 9'h0, 1'b1, 1'b0, 12'h000);
      tick();
      chk_o($sformatf("t4_frozen%0d", k), 9'h0AB, 1'b1);
    end
    set_o(1'b0, 12'h0, 9'h0, 1'b0, 1'b1, 12'h0);
    tick();
    chk_o("t4_release", 9'h155, 1'b1);
    tick();
    chk_o("t4_drain", 9'h155, 1'b0);

    // Reset in the middle of back-to-back reads on the default build.
    set_d(1'b1, 12'h010, 9'h0F0, 1'b0, 12'h0);
    tick();
    set_d(1'b0, 12'h0, 9'h0, 1'b1, 12'h123);
    tick();
    chk_d("t5_rd0", 9'h1A5, 1'b1);
    set_d(1'b0, 12'h0, 9'h0, 1'b1, 12'h010);
    tick();
    chk_d("t5_rd1", 9'h0F0, 1'b1);
    reset = 1'b1;
    set_d(1'b1, 12'h020, 9'h1FF, 1'b1, 12'h123);
    tick();
    chk_d("t5_in_reset", 9'h0, 1'b0);
    reset = 1'b0;
    set_d(1'b0, 12'h0, 9'h0, 1'b0, 12'h0);
    tick();
    chk_d("t5_post_idle", 9'h0, 1'b0);
    set_d(1'b0, 12'h0, 9'h0, 1'b1, 12'h010);
    tick();
    chk_d("t5_survive", 9'h0F0, 1'b1);
    set_d(1'b0, 12'h0, 9'h0, 1'b1, 12'h020);
    tick();
    chk_d("t5_no_write", 9'h000, 1'b1);
    set_d(1'b0, 12'h0, 9'h0, 1'b0, 12'h0);

    // Random traffic on both 4-lane builds, biased to a few addresses for collisions.
    for (int c = 0; c < 10000; c++) begin
      logic [7:0] aa, ab;
      aa = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      ab = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 199) == 0);
      set_wide(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), aa, 32'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ab);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
